mult_issue_queue: RTL and testbench

- Data-capture reservation station directly upstream of the multiply functional unit.
- Accepts dispatched multiply ops, captures operand values at dispatch or from CDB broadcasts, and issues one ready op at a time to the unit.
- Holds operands and funct3 stable for the whole multiply, then presents the tagged result to the CDB arbiter with a valid/ready handshake.
- Sits between dispatch/rename and the multiplier; one multiply in flight at a time.

---
 rtl/mult_issue_queue.sv | 198 +++++++++++++++++++
 tb/tb_mult_issue_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_queue.sv
// mult_issue_queue
// Data-capture reservation station feeding a single multiply unit.
// Dispatched ops capture ready operands immediately and pick up missing ones
// from CDB broadcasts. One op at a time is issued. Its operands are held
// steady for the whole multiply, and the tagged result is offered to the
// CDB arbiter with a valid/ready handshake.
//
// Ports
//   clk, rst_n               clock, async active-low reset
//   flush                    drop all entries and any in-flight op
//   disp_*                   dispatch request / op fields, disp_ready = free slot
//   cdb_valid/pd/v           result broadcast used for operand wakeup
//   fu_rs1_v/rs2_v/funct3    operands to multiplier, fu_start one-cycle pulse
//   fu_valid/fu_rd_v         multiplier completion pulse and result
//   res_valid/ready/v/pd/rob tagged result handshake to CDB arbiter
module mult_issue_queue #(
    parameter int DEPTH         = 4,
    parameter int PHYS_REG_BITS = 6,
    parameter int ROB_IDX_BITS  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [2:0]               disp_funct3,
    input  logic [PHYS_REG_BITS-1:0] disp_ps1,
    input  logic [PHYS_REG_BITS-1:0] disp_ps2,
    input  logic                     disp_rdy1,
    input  logic                     disp_rdy2,
    input  logic [31:0]              disp_v1,
    input  logic [31:0]              disp_v2,
    input  logic [PHYS_REG_BITS-1:0] disp_pd,
    input  logic [ROB_IDX_BITS-1:0]  disp_rob,
    input  logic                     cdb_valid,
    input  logic [PHYS_REG_BITS-1:0] cdb_pd,
    input  logic [31:0]              cdb_v,
    output logic [31:0]              fu_rs1_v,
    output logic [31:0]              fu_rs2_v,
    output logic [2:0]               fu_funct3,
    output logic                     fu_start,
    input  logic                     fu_valid,
    input  logic [31:0]              fu_rd_v,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_v,
    output logic [PHYS_REG_BITS-1:0] res_pd,
    output logic [ROB_IDX_BITS-1:0]  res_rob
);
    localparam int IW = $clog2(DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] BUSY  = 3'd2;
    localparam logic [2:0] RESP  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    // Entry storage
    logic [DEPTH-1:0]         r_vld, r_rdy1, r_rdy2;
    logic [2:0]               r_f3  [DEPTH];
    logic [PHYS_REG_BITS-1:0] r_ps1 [DEPTH];
    logic [PHYS_REG_BITS-1:0] r_ps2 [DEPTH];
    logic [31:0]              r_v1  [DEPTH];
    logic [31:0]              r_v2  [DEPTH];
    logic [PHYS_REG_BITS-1:0] r_epd [DEPTH];
    logic [ROB_IDX_BITS-1:0]  r_erob[DEPTH];

    // Issue / result registers
    logic [2:0]               r_state;
    logic [31:0]              r_rs1, r_rs2, r_res_v;
    logic [2:0]               r_fu_f3;
    logic [PHYS_REG_BITS-1:0] r_pd;
    logic [ROB_IDX_BITS-1:0]  r_rob;

    logic          w_free_found, w_sel_found, w_alloc, w_issue;
    logic [IW-1:0] w_free_idx, w_sel_idx;

    // Lowest-index free slot and lowest-index fully ready entry. Both are
    // computed from registered state only, so a wakeup this cycle is eligible
    // next cycle.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!r_vld[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IW'(i);
            end
            if (r_vld[i] && r_rdy1[i] && r_rdy2[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IW'(i);
            end
        end
    end

    assign disp_ready = w_free_found;
    assign w_alloc    = disp_valid && disp_ready && !flush;
    assign w_issue    = (r_state == IDLE) && w_sel_found && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_rdy1 <= '0;
            r_rdy2 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_f3[i]   <= '0;
                r_ps1[i]  <= '0;
                r_ps2[i]  <= '0;
                r_v1[i]   <= '0;
                r_v2[i]   <= '0;
                r_epd[i]  <= '0;
                r_erob[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_vld[i] && cdb_valid) begin
                    if (!r_rdy1[i] && r_ps1[i] == cdb_pd) begin
                        r_rdy1[i] <= 1'b1;
                        r_v1[i]   <= cdb_v;
                    end
                    if (!r_rdy2[i] && r_ps2[i] == cdb_pd) begin
                        r_rdy2[i] <= 1'b1;
                        r_v2[i]   <= cdb_v;
                    end
                end
            end
            // Issue and allocation can never target the same slot: one
            // picks a valid entry, the other an invalid one.
            if (w_issue)
                r_vld[w_sel_idx] <= 1'b0;
            if (w_alloc) begin
                r_vld[w_free_idx]  <= 1'b1;
                r_f3[w_free_idx]   <= disp_funct3;
                r_ps1[w_free_idx]  <= disp_ps1;
                r_ps2[w_free_idx]  <= disp_ps2;
                r_epd[w_free_idx]  <= disp_pd;
                r_erob[w_free_idx] <= disp_rob;
                // A same-cycle broadcast of a missing source counts as
                // captured at dispatch.
                r_rdy1[w_free_idx] <= disp_rdy1 || (cdb_valid && cdb_pd == disp_ps1);
                r_v1[w_free_idx]   <= disp_rdy1 ? disp_v1 : cdb_v;
                r_rdy2[w_free_idx] <= disp_rdy2 || (cdb_valid && cdb_pd == disp_ps2);
                r_v2[w_free_idx]   <= disp_rdy2 ? disp_v2 : cdb_v;
            end
            if (flush)
                r_vld <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_fu_f3 <= '0;
            r_pd    <= '0;
            r_rob   <= '0;
            r_res_v <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_issue) begin
                    r_rs1   <= r_v1[w_sel_idx];
                    r_rs2   <= r_v2[w_sel_idx];
                    r_fu_f3 <= r_f3[w_sel_idx];
                    r_pd    <= r_epd[w_sel_idx];
                    r_rob   <= r_erob[w_sel_idx];
                    r_state <= START;
                end
                START, BUSY: begin
                    if (flush)
                        // If the completion lands in the flush cycle itself
                        // there is nothing left to drain.
                        r_state <= fu_valid ? IDLE : DRAIN;
                    else if (fu_valid) begin
                        r_res_v <= fu_rd_v;
                        r_state <= RESP;
                    end else
                        r_state <= BUSY;
                end
                RESP:  if (flush || res_ready) r_state <= IDLE;
                DRAIN: if (fu_valid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fu_start  = (r_state == START);
    assign res_valid = (r_state == RESP);
    assign fu_rs1_v  = r_rs1;
    assign fu_rs2_v  = r_rs2;
    assign fu_funct3 = r_fu_f3;
    assign res_v     = r_res_v;
    assign res_pd    = r_pd;
    assign res_rob   = r_rob;

endmodule

// File: tb/tb_mult_issue_queue.sv
module tb_mult_issue_queue;
    localparam int LAT = 3;

    logic        clk, rst_n, flush;
    logic        disp_valid, disp_ready, disp_rdy1, disp_rdy2;
    logic [2:0]  disp_funct3;
    logic [5:0]  disp_ps1, disp_ps2, disp_pd;
    logic [31:0] disp_v1, disp_v2;
    logic [4:0]  disp_rob;
    logic        cdb_valid;
    logic [5:0]  cdb_pd;
    logic [31:0] cdb_v;
    logic [31:0] fu_rs1_v, fu_rs2_v, fu_rd_v;
    logic [2:0]  fu_funct3;
    logic        fu_start, fu_valid;
    logic        res_valid, res_ready;
    logic [31:0] res_v;
    logic [5:0]  res_pd;
    logic [4:0]  res_rob;

    int n_chk = 0;
    int n_fail = 0;

    mult_issue_queue #(.DEPTH(4), .PHYS_REG_BITS(6), .ROB_IDX_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_funct3(disp_funct3),
        .disp_ps1(disp_ps1), .disp_ps2(disp_ps2), .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
        .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_pd(disp_pd), .disp_rob(disp_rob),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_v(cdb_v),
        .fu_rs1_v(fu_rs1_v), .fu_rs2_v(fu_rs2_v), .fu_funct3(fu_funct3), .fu_start(fu_start),
        .fu_valid(fu_valid), .fu_rd_v(fu_rd_v),
        .res_valid(res_valid), .res_ready(res_ready), .res_v(res_v),
        .res_pd(res_pd), .res_rob(res_rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: fixed latency LAT from the start pulse.
    function automatic logic [31:0] mulres(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
        logic [63:0] ea, eb, p;
        ea = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (f == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (f == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    logic [31:0] m_a, m_b;
    logic [2:0]  m_f;
    int          m_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fu_valid <= 1'b0;
            fu_rd_v  <= '0;
            m_cnt    <= 0;
            m_a      <= '0;
            m_b      <= '0;
            m_f      <= '0;
        end else begin
            fu_valid <= 1'b0;
            if (fu_start) begin
                m_a   <= fu_rs1_v;
                m_b   <= fu_rs2_v;
                m_f   <= fu_funct3;
                m_cnt <= LAT - 1;
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    fu_valid <= 1'b1;
                    fu_rd_v  <= mulres(m_a, m_b, m_f);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [2:0] f3, input logic [5:0] ps1, input logic r1,
                            input logic [31:0] v1, input logic [5:0] ps2, input logic r2,
                            input logic [31:0] v2, input logic [5:0] pd, input logic [4:0] rob);
        disp_valid = 1'b1; disp_funct3 = f3;
        disp_ps1 = ps1; disp_rdy1 = r1; disp_v1 = v1;
        disp_ps2 = ps2; disp_rdy2 = r2; disp_v2 = v2;
        disp_pd = pd; disp_rob = rob;
    endtask

    task automatic clr_disp;
        disp_valid = 1'b0;
    endtask

    task automatic wait_res(input int maxc);
        int n;
        n = 0;
        while (!res_valid && n < maxc) begin
            tick;
            n++;
        end
        chk("res_valid_within_budget", {31'b0, res_valid}, 32'd1);
    endtask

    task automatic accept;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int ncyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            tick;
            if (fu_start || res_valid) seen = 1'b1;
        end
        chk(tag, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; res_ready = 1'b0;
        disp_valid = 1'b0; disp_funct3 = '0; disp_ps1 = '0; disp_ps2 = '0;
        disp_rdy1 = 1'b0; disp_rdy2 = 1'b0; disp_v1 = '0; disp_v2 = '0;
        disp_pd = '0; disp_rob = '0;
        cdb_valid = 1'b0; cdb_pd = '0; cdb_v = '0;
        #12;
        chk("rst_fu_start", {31'b0, fu_start}, 32'd0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_disp_ready", {31'b0, disp_ready}, 32'd1);
        chk("rst_res_v", res_v, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick;

        // MUL 7 x -3, both ready, L=3
        set_disp(3'd0, 6'd1, 1'b1, 32'd7, 6'd2, 1'b1, 32'hFFFFFFFD, 6'd5, 5'd3);
        tick; clr_disp;                                   // cycle 1
        chk("t1_c1_fu_start", {31'b0, fu_start}, 32'd0);
        tick;                                             // cycle 2
        chk("t1_c2_fu_start", {31'b0, fu_start}, 32'd1);
        chk("t1_c2_rs1", fu_rs1_v, 32'd7);
        tick;                                             // cycle 3
        chk("t1_c3_fu_start", {31'b0, fu_start}, 32'd0);
        tick; tick;                                       // cycle 5
        chk("t1_c5_fu_valid", {31'b0, fu_valid}, 32'd1);
        chk("t1_c5_rs1_held", fu_rs1_v, 32'd7);
        chk("t1_c5_rs2_held", fu_rs2_v, 32'hFFFFFFFD);
        chk("t1_c5_res_valid", {31'b0, res_valid}, 32'd0);
        tick;                                             // cycle 6
        chk("t1_c6_res_valid", {31'b0, res_valid}, 32'd1);
        chk("t1_res_v", res_v, 32'hFFFFFFEB);
        chk("t1_res_pd", {26'b0, res_pd}, 32'd5);
        chk("t1_res_rob", {27'b0, res_rob}, 32'd3);
        accept;
        chk("t1_res_valid_drop", {31'b0, res_valid}, 32'd0);

        // MULHU with rs2 woken by CDB in cycle 4
        set_disp(3'd3, 6'd1, 1'b1, 32'hFFFFFFFF, 6'd9, 1'b0, 32'd0, 6'd6, 5'd4);
        tick; clr_disp;                                   // cycle 1
        tick; tick; tick;                                 // cycle 4
        chk("t2_c4_fu_start", {31'b0, fu_start}, 32'd0);
        cdb_valid = 1'b1; cdb_pd = 6'd9; cdb_v = 32'hFFFFFFFF;
        tick; cdb_valid = 1'b0;                           // cycle 5
        chk("t2_c5_fu_start", {31'b0, fu_start}, 32'd0);
        tick;                                             // cycle 6
        chk("t2_c6_fu_start", {31'b0, fu_start}, 32'd1);
        chk("t2_rs2", fu_rs2_v, 32'hFFFFFFFF);
        wait_res(10);
        chk("t2_res_v", res_v, 32'hFFFFFFFE);
        chk("t2_res_pd", {26'b0, res_pd}, 32'd6);
        accept;

        // Fill queue with ops waiting on tag 12
        for (int k = 0; k < 4; k++) begin
            set_disp(3'd0, 6'd12, 1'b0, 32'd0, 6'd1, 1'b1, 32'(k + 1), 6'(20 + k), 5'(1 + k));
            tick;
        end
        clr_disp;
        chk("t3_full_disp_ready", {31'b0, disp_ready}, 32'd0);
        set_disp(3'd0, 6'd12, 1'b0, 32'd0, 6'd1, 1'b1, 32'd5, 6'd24, 5'd5);
        tick; clr_disp;
        chk("t3_still_full", {31'b0, disp_ready}, 32'd0);
        chk("t3_no_issue", {31'b0, fu_start}, 32'd0);
        cdb_valid = 1'b1; cdb_pd = 6'd12; cdb_v = 32'h10;
        tick; cdb_valid = 1'b0;
        chk("t3_wake_disp_ready", {31'b0, disp_ready}, 32'd0);
        tick;
        chk("t3_first_issue_start", {31'b0, fu_start}, 32'd1);
        chk("t3_ready_after_issue", {31'b0, disp_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            wait_res(12);
            chk("t3_order_pd", {26'b0, res_pd}, 32'(20 + k));
            chk("t3_res_v", res_v, 32'(16 * (k + 1)));
            tick;
            chk("t3_held_valid", {31'b0, res_valid}, 32'd1);
            chk("t3_held_rob", {27'b0, res_rob}, 32'(1 + k));
            accept;
        end
        idle_check("t3_fifth_dropped", 12);

        // Dispatch wakeup from same-cycle CDB
        set_disp(3'd0, 6'd7, 1'b0, 32'd0, 6'd2, 1'b1, 32'd3, 6'd8, 5'd8);
        cdb_valid = 1'b1; cdb_pd = 6'd7; cdb_v = 32'h10;
        tick; clr_disp; cdb_valid = 1'b0;
        tick;
        chk("t4_fu_start", {31'b0, fu_start}, 32'd1);
        chk("t4_rs1", fu_rs1_v, 32'h10);
        wait_res(10);
        chk("t4_res_v", res_v, 32'h30);
        accept;

        // Flush in BUSY, pending waiter flushed, dispatch in flush cycle ignored
        set_disp(3'd0, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd6, 6'd30, 5'd9);
        tick;                                             // cycle 1
        set_disp(3'd0, 6'd40, 1'b0, 32'd0, 6'd2, 1'b1, 32'd1, 6'd32, 5'd10);
        tick; clr_disp;                                   // cycle 2
        chk("t5_fu_start", {31'b0, fu_start}, 32'd1);
        tick;                                             // cycle 3 BUSY
        flush = 1'b1;
        set_disp(3'd0, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd1, 6'd33, 5'd11);
        tick; flush = 1'b0; clr_disp;                     // cycle 4 DRAIN
        cdb_valid = 1'b1; cdb_pd = 6'd40; cdb_v = 32'd1;
        chk("t5_c4_res_valid", {31'b0, res_valid}, 32'd0);
        tick; cdb_valid = 1'b0;                           // cycle 5
        chk("t5_c5_res_valid", {31'b0, res_valid}, 32'd0);
        tick;                                             // cycle 6
        chk("t5_c6_res_valid", {31'b0, res_valid}, 32'd0);
        set_disp(3'd0, 6'd1, 1'b1, 32'd9, 6'd2, 1'b1, 32'd9, 6'd31, 5'd12);
        tick; clr_disp;
        wait_res(12);
        chk("t5_new_pd", {26'b0, res_pd}, 32'd31);
        chk("t5_new_v", res_v, 32'd81);
        accept;
        idle_check("t5_nothing_after", 10);

        // Result held 5 cycles with res_ready low
        set_disp(3'd0, 6'd1, 1'b1, 32'd2, 6'd2, 1'b1, 32'd3, 6'd7, 5'd7);
        tick; clr_disp;
        wait_res(12);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("t6_hold_valid", {31'b0, res_valid}, 32'd1);
            chk("t6_hold_v", res_v, 32'd6);
            chk("t6_hold_pd", {26'b0, res_pd}, 32'd7);
            chk("t6_hold_rob", {27'b0, res_rob}, 32'd7);
        end
        accept;

        // Async reset mid-BUSY
        set_disp(3'd1, 6'd1, 1'b1, 32'd4, 6'd2, 1'b1, 32'd5, 6'd3, 5'd2);
        tick; clr_disp;
        tick; tick;                                       // BUSY
        chk("t7_busy_rs1", fu_rs1_v, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_rs1", fu_rs1_v, 32'd0);
        chk("t7_rst_rs2", fu_rs2_v, 32'd0);
        chk("t7_rst_f3", {29'b0, fu_funct3}, 32'd0);
        chk("t7_rst_res_v", res_v, 32'd0);
        chk("t7_rst_res_pd", {26'b0, res_pd}, 32'd0);
        chk("t7_rst_res_rob", {27'b0, res_rob}, 32'd0);
        chk("t7_rst_fu_start", {31'b0, fu_start}, 32'd0);
        chk("t7_rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("t7_rst_disp_ready", {31'b0, disp_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        idle_check("t7_quiet_after_reset", 8);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
